// File: rtl/uart_alu_sequencer.sv
// Command sequencer: collects operand A, operand B and opcode bytes from uart_rx, runs them
// through the ALU and sends the result byte to uart_tx. Optional inactivity timeout: UART_SEQ_TIMEOUT_EN.
module uart_alu_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_error
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t state, next_state;
  logic   accept, counting, expired, timeout_hit;

  if (NB_TIMEOUT < $clog2(TIMEOUT_CYCLES)) begin : g_timeout_width_check
    $error("NB_TIMEOUT is too narrow to count TIMEOUT_CYCLES");
  end

  // A byte is only taken while the FSM is collecting a command; elsewhere it is dropped.
  assign accept   = i_rx_valid && (state == S_WAIT_A || state == S_WAIT_B || state == S_WAIT_OP);
  assign counting = (state == S_WAIT_B) || (state == S_WAIT_OP) || (state == S_WAIT_TX);
  assign timeout_hit = expired && counting && !i_rx_valid && !i_tx_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= S_WAIT_A;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WAIT_A:  if (i_rx_valid) next_state = S_WAIT_B;
      S_WAIT_B: begin
        if (i_rx_valid)       next_state = S_WAIT_OP;
        else if (timeout_hit) next_state = S_WAIT_A;
      end
      S_WAIT_OP: begin
        if (i_rx_valid)       next_state = S_EXEC;
        else if (timeout_hit) next_state = S_WAIT_A;
      end
      S_EXEC:    next_state = S_SEND;
      S_SEND:    next_state = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done || timeout_hit) next_state = S_WAIT_A;
      end
      default:   next_state = S_WAIT_A;
    endcase
  end

  // Operand/opcode/result registers hold until overwritten; reset clears partial commands.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
    end else begin
      if (state == S_WAIT_A && i_rx_valid)  o_alu_a  <= i_rx_data;
      if (state == S_WAIT_B && i_rx_valid)  o_alu_b  <= i_rx_data;
      if (state == S_WAIT_OP && i_rx_valid) o_alu_op <= i_rx_data[NB_OP-1:0];
      if (state == S_EXEC)                  o_tx_data <= i_alu_result;
    end
  end

  assign o_tx_start = (state == S_SEND);
  assign o_busy     = (state == S_EXEC) || (state == S_SEND) || (state == S_WAIT_TX);

`ifdef UART_SEQ_TIMEOUT_EN
  localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] idle_cnt;
  logic                  error_pulse;

  // Counter restarts on any accepted byte or state change, so it measures time spent idle in one wait state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idle_cnt    <= '0;
      error_pulse <= 1'b0;
    end else begin
      error_pulse <= timeout_hit;
      if (accept || (next_state != state) || !counting) idle_cnt <= '0;
      else                                              idle_cnt <= idle_cnt + NB_TIMEOUT'(1);
    end
  end

  assign expired = (idle_cnt >= LAST_COUNT);
  assign o_error = error_pulse;
`else
  assign expired = 1'b0;
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: directed scenarios plus randomized commands
// checked against a byte-level command model with a behavioural ALU.
module tb_uart_alu_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;

  uart_alu_sequencer #(
    .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(100), .NB_TIMEOUT(20)
  ) dut (
    .i_clock(clock), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_alu_result(alu_result), .i_tx_done(tx_done), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_op(alu_op), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    alu_result = 8'h00;
    if (alu_op == 6'h20)      alu_result = alu_a + alu_b;
    else if (alu_op == 6'h24) alu_result = alu_a & alu_b;
  end

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return 8'((int'(a) + int'(b)) % 256);
      6'h24:   return a & b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic exec_op(input logic [7:0] opb);
    send_byte(opb);
    m_op = opb[5:0];
    m_tx = ref_alu(m_a, m_b, m_op);
    check("alu_op", alu_op, m_op);
    check("busy_exec", busy, 1);
    check("start_early", tx_start, 0);
    tick();
    check("start_pulse", tx_start, 1);
    check("tx_data", tx_data, m_tx);
    tick();
    check("start_single", tx_start, 0);
    check("busy_wait_tx", busy, 1);
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb, input int gap);
    send_byte(a);
    m_a = a;
    check("alu_a", alu_a, m_a);
    check("busy_collect", busy, 0);
    idle(gap);
    send_byte(b);
    m_b = b;
    check("alu_b", alu_b, m_b);
    idle(gap);
    exec_op(opb);
  endtask

  // Waits out uart_tx (~20 cycles), optionally injecting a byte that must be dropped.
  task automatic finish_tx(input bit drop, input logic [7:0] drop_byte);
    int starts = 0;
    for (int i = 0; i < 17; i++) begin
      if (drop && i == 5) begin
        rx_data  = drop_byte;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (tx_start) starts++;
    end
    check("extra_start", starts, 0);
    check("busy_before_done", busy, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("busy_after_done", busy, 0);
    check("a_kept", alu_a, m_a);
    check("tx_kept", tx_data, m_tx);
    check("no_error", error, 0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_done  = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
    idle(2);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_op", alu_op, 0);
    check("rst_tx", tx_data, 0);
    check("rst_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    tick();

    // T1: ADD 5 + 3
    send_cmd(8'h05, 8'h03, 8'h20, 0);
    check("t1_tx", tx_data, 8'h08);
    finish_tx(1'b0, 8'h00);

    // T2: opcode byte upper bits discarded, AND
    send_cmd(8'hF0, 8'h3C, 8'hE4, 1);
    check("t2_op", alu_op, 6'h24);
    check("t2_tx", tx_data, 8'h30);
    // T3: byte during transmit is dropped
    finish_tx(1'b1, 8'hAA);
    send_cmd(8'h0F, 8'h01, 8'h20, 0);
    check("t3_a", alu_a, 8'h0F);
    check("t3_tx", tx_data, 8'h10);
    finish_tx(1'b0, 8'h00);

    // T4: reset while waiting for the opcode
    send_byte(8'h44);
    send_byte(8'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
    check("t4_a", alu_a, 0);
    check("t4_b", alu_b, 0);
    check("t4_tx", tx_data, 0);
    check("t4_busy", busy, 0);
    send_byte(8'h11);
    m_a = 8'h11;
    check("t4_next_a", alu_a, 8'h11);
    check("t4_b_clear", alu_b, 0);
    send_byte(8'h22);
    m_b = 8'h22;
    exec_op(8'h20);
    check("t4_tx_sum", tx_data, 8'h33);
    finish_tx(1'b0, 8'h00);

    // T5: rx byte together with tx_done
    send_cmd(8'h81, 8'h7F, 8'h20, 0);
    idle(17);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tx_done  = 1'b1;
    tick();
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_a", alu_a, 8'h81);
    send_cmd(8'h09, 8'h06, 8'h24, 0);
    check("t5_next_tx", tx_data, 8'h00);
    finish_tx(1'b0, 8'h00);

    // Randomized commands
    for (int n = 0; n < 12; n++) begin
      logic [7:0] ra, rb, ro;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ro = {2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 6'h20 : 6'h24};
      send_cmd(ra, rb, ro, int'($urandom_range(0, 4)));
      finish_tx(($urandom_range(0, 1) != 0), 8'($urandom_range(0, 255)));
    end

    // T6: idle after operand A only
    send_byte(8'h5A);
    m_a = 8'h5A;
    check("t6_a", alu_a, 8'h5A);
`ifdef UART_SEQ_TIMEOUT_EN
    begin
      int pulses = 0;
      int at     = -1;
      for (int i = 1; i <= 150; i++) begin
        tick();
        if (error) begin
          pulses++;
          if (at < 0) at = i;
        end
      end
      check("t6_pulses", pulses, 1);
      check("t6_when", at, 100);
      check("t6_busy", busy, 0);
      check("t6_a_kept", alu_a, 8'h5A);
      send_cmd(8'h33, 8'h01, 8'h20, 0);
      check("t6_new_a", alu_a, 8'h33);
      finish_tx(1'b0, 8'h00);
    end
`else
    begin
      int pulses = 0;
      for (int i = 1; i <= 150; i++) begin
        tick();
        if (error !== 1'b0) pulses++;
      end
      check("t6_no_error", pulses, 0);
      send_byte(8'h33);
      m_b = 8'h33;
      check("t6_became_b", alu_b, 8'h33);
      check("t6_a_kept", alu_a, 8'h5A);
      exec_op(8'h20);
      check("t6_tx", tx_data, 8'h8D);
      finish_tx(1'b0, 8'h00);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
